// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and FSM states.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        IDLE  = 2'b01,
        BUSY  = 2'b10,
        RESP  = 2'b11
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store merge, load extract/extend, misalignment detect.
// Half/word offsets are always aligned down; the caller decides whether misalignment is an error.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [1:0]  off;
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] picked;

    always_comb begin
        off       = addr;
        lane_mask = '0;
        misalign  = ((size == SIZE_HALF) && addr[0]) ||
                    ((size == SIZE_WORD) && (addr != 2'b00));
        case (size)
            SIZE_BYTE: lane_mask = 32'h0000_00FF;
            SIZE_HALF: begin
                off       = {addr[1], 1'b0};
                lane_mask = 32'h0000_FFFF;
            end
            SIZE_WORD: begin
                off       = 2'b00;
                lane_mask = 32'hFFFF_FFFF;
            end
            default:   lane_mask = '0;
        endcase
        sh     = {off, 3'b000};
        // Illegal size has an empty mask, so the merge leaves the word untouched.
        merged = (old_word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
        picked = (old_word >> sh) & lane_mask;
        case (size)
            SIZE_BYTE: rdata = uns ? picked : {{24{picked[7]}}, picked[7:0]};
            SIZE_HALF: rdata = uns ? picked : {{16{picked[15]}}, picked[15:0]};
            SIZE_WORD: rdata = picked;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte/half/word data memory with valid/ready requests, configurable read latency and post-reset clear.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them down.
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1,
    localparam int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              init_done
);

    localparam int IDX_W = ADDR_W - 2;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    logic [31:0]      mem [DEPTH];
    dmem_state_t      state, state_nxt;
    logic [IDX_W-1:0] clr_ptr;
    logic [3:0]       lat_cnt;
    logic [31:0]      pend_rdata;
    logic             pend_error;

    logic [IDX_W-1:0] widx;
    logic [31:0]      old_word, merged, load_val, acc_rdata;
    logic             misalign, accept, acc_error, clr_last;

    assign widx      = req_addr[ADDR_W-1:2];
    assign old_word  = mem[widx];
    assign accept    = req_valid && req_ready;
    assign acc_error = (req_size == SIZE_ILL) || (MISALIGN_CHK && misalign);
    assign acc_rdata = (acc_error || req_write) ? 32'h0 : load_val;
    assign clr_last  = (clr_ptr == IDX_W'(DEPTH - 1));

    dmem_lane_align u_align (
        .addr     (req_addr[1:0]),
        .size     (req_size),
        .uns      (req_unsigned),
        .wdata    (req_wdata),
        .old_word (old_word),
        .merged   (merged),
        .rdata    (load_val),
        .misalign (misalign)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            CLEAR: if (clr_last) state_nxt = IDLE;
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (LATENCY > 1) ? BUSY : RESP;
            end
            BUSY: if (lat_cnt == 4'(LATENCY - 2)) state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            lat_cnt    <= '0;
            init_done  <= 1'b0;
            pend_rdata <= '0;
            pend_error <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_last) init_done <= 1'b1;
            end
            // The result is captured at acceptance; it reaches the outputs on entry to RESP.
            if (accept) begin
                pend_rdata <= acc_rdata;
                pend_error <= acc_error;
                lat_cnt    <= '0;
                if (LATENCY == 1) begin
                    rsp_rdata <= acc_rdata;
                    rsp_error <= acc_error;
                end
            end
            if (state == BUSY) begin
                lat_cnt <= lat_cnt + 1'b1;
                if (state_nxt == RESP) begin
                    rsp_rdata <= pend_rdata;
                    rsp_error <= pend_error;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (accept && req_write && !acc_error)
                mem[widx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=2, both DEPTH=128.
module tb_data_memory_bytelane;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic [1:0] reset;
  logic [1:0] req_valid, req_ready, req_write, req_uns, rsp_valid, rsp_error, init_done;
  logic [1:0][1:0] req_size;
  logic [1:0][8:0] req_addr;
  logic [1:0][31:0] req_wdata, rsp_rdata;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  data_memory_bytelane #(.DEPTH(128), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_uns[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]), .init_done(init_done[0])
  );

  data_memory_bytelane #(.DEPTH(128), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_uns[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]), .init_done(init_done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: one request, then wait for its response and score it
  task automatic do_req(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    logic [31:0] exp_v;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d]  = sz;
    req_uns[d]   = uns;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    exp_q.push_back(exp_rd);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[d] && n < 20);
    exp_v = exp_q.pop_front();
    check({tag, "_latency"}, 32'(n), (d == 0) ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, rsp_rdata[d], exp_v);
    check({tag, "_error"}, 32'(rsp_error[d]), 32'(exp_err));
  endtask

  // hold req_valid high and measure the spacing between acceptances
  task automatic spacing(input int d, input int gap, input string tag);
    int acc[$];
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = 1'b0;
    req_size[d]  = SIZE_WORD;
    req_uns[d]   = 1'b0;
    req_addr[d]  = 9'h010;
    req_wdata[d] = '0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready[d]) acc.push_back(i);
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    repeat (4) @(negedge clk);
    if (acc.size() < 3) check({tag, "_accept_count"}, 32'(acc.size()), 32'd3);
    else begin
      check({tag, "_gap0"}, 32'(acc[1] - acc[0]), 32'(gap));
      check({tag, "_gap1"}, 32'(acc[2] - acc[1]), 32'(gap));
    end
  endtask

  initial begin
    int cnt;
    int bad_ready;
    int pulses;
    reset = 2'b11;
    req_valid = '0; req_write = '0; req_uns = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rdata", rsp_rdata[d], 32'd0);
      check("rst_error", 32'(rsp_error[d]), 32'd0);
      check("rst_init_done", 32'(init_done[d]), 32'd0);
    end
    reset = 2'b00;

    // clear phase: count cycles spent with init_done low
    cnt = 0;
    bad_ready = 0;
    while (!init_done[0] && cnt < 400) begin
      if (req_ready[0]) bad_ready++;
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles", 32'(cnt), 32'd128);
    check("clear_ready_low", 32'(bad_ready), 32'd0);
    check("clear_ready_rise", 32'(req_ready[0]), 32'd1);

    // LATENCY=1 instance
    do_req(0, 1'b0, SIZE_WORD, 1'b0, 9'h1FC, 32'h0, 32'h0000_0000, 1'b0, "l1_lw_1fc");
    do_req(0, 1'b1, SIZE_HALF, 1'b0, 9'h1FE, 32'h1234_BEEF, 32'h0, 1'b0, "l1_sh_1fe");
    do_req(0, 1'b0, SIZE_HALF, 1'b0, 9'h1FE, 32'h0, 32'hFFFF_BEEF, 1'b0, "l1_lh_1fe");
    do_req(0, 1'b0, SIZE_WORD, 1'b0, 9'h1FC, 32'h0, 32'hBEEF_0000, 1'b0, "l1_lw_1fc_b");
    spacing(0, 2, "l1_thru");

    // LATENCY=2 instance
    do_req(1, 1'b1, SIZE_WORD, 1'b0, 9'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_10");
    do_req(1, 1'b0, SIZE_BYTE, 1'b0, 9'h011, 32'h0, 32'hFFFF_FFBE, 1'b0, "lb_11");
    do_req(1, 1'b0, SIZE_BYTE, 1'b1, 9'h013, 32'h0, 32'h0000_00DE, 1'b0, "lbu_13");
    @(negedge clk);
    check("hold_rdata", rsp_rdata[1], 32'h0000_00DE);
    check("hold_valid_low", 32'(rsp_valid[1]), 32'd0);
    do_req(1, 1'b0, SIZE_HALF, 1'b0, 9'h012, 32'h0, 32'hFFFF_DEAD, 1'b0, "lh_12");
    do_req(1, 1'b0, SIZE_HALF, 1'b1, 9'h010, 32'h0, 32'h0000_BEEF, 1'b0, "lhu_10");

    do_req(1, 1'b1, SIZE_WORD, 1'b0, 9'h020, 32'h0, 32'h0, 1'b0, "sw_20");
    do_req(1, 1'b1, SIZE_BYTE, 1'b0, 9'h021, 32'hFFFF_FF5A, 32'h0, 1'b0, "sb_21");
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h020, 32'h0, 32'h0000_5A00, 1'b0, "lw_20");
    do_req(1, 1'b1, SIZE_HALF, 1'b0, 9'h022, 32'h0000_8001, 32'h0, 1'b0, "sh_22");
    do_req(1, 1'b0, SIZE_HALF, 1'b1, 9'h022, 32'h0, 32'h0000_8001, 1'b0, "lhu_22");
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h020, 32'h0, 32'h8001_5A00, 1'b0, "lw_20_b");

    do_req(1, 1'b1, SIZE_WORD, 1'b0, 9'h004, 32'h1122_3344, 32'h0, 1'b0, "sw_04");
`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h006, 32'h0, 32'h0, 1'b1, "lw_06_mis");
    do_req(1, 1'b0, SIZE_HALF, 1'b0, 9'h005, 32'h0, 32'h0, 1'b1, "lh_05_mis");
    do_req(1, 1'b1, SIZE_HALF, 1'b0, 9'h007, 32'hFFFF_FFFF, 32'h0, 1'b1, "sh_07_mis");
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h004, 32'h0, 32'h1122_3344, 1'b0, "lw_04_kept");
`else
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h006, 32'h0, 32'h1122_3344, 1'b0, "lw_06_align");
    do_req(1, 1'b0, SIZE_HALF, 1'b0, 9'h005, 32'h0, 32'h0000_3344, 1'b0, "lh_05_align");
    do_req(1, 1'b1, SIZE_HALF, 1'b0, 9'h007, 32'h0000_A5A5, 32'h0, 1'b0, "sh_07_align");
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h004, 32'h0, 32'hA5A5_3344, 1'b0, "lw_04_merged");
`endif

    do_req(1, 1'b1, SIZE_WORD, 1'b0, 9'h030, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_30");
    do_req(1, 1'b1, SIZE_ILL, 1'b0, 9'h030, 32'hFFFF_FFFF, 32'h0, 1'b1, "ill_st_30");
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h030, 32'h0, 32'hCAFE_F00D, 1'b0, "lw_30_kept");
    do_req(1, 1'b0, SIZE_ILL, 1'b0, 9'h030, 32'h0, 32'h0, 1'b1, "ill_ld_30");
    spacing(1, 3, "l2_thru");

    // reset while a load sits in BUSY
    do_req(1, 1'b1, SIZE_WORD, 1'b0, 9'h040, 32'h1234_5678, 32'h0, 1'b0, "sw_40");
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = SIZE_WORD; req_addr[1] = 9'h040;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 135; i++) begin
      if (rsp_valid[1]) pulses++;
      @(negedge clk);
    end
    check("midreset_no_rsp", 32'(pulses), 32'd0);
    check("midreset_init_done", 32'(init_done[1]), 32'd1);
    do_req(1, 1'b0, SIZE_WORD, 1'b0, 9'h040, 32'h0, 32'h0, 1'b0, "lw_40_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
